// File: rtl/id_ex_skid_stage.sv
// ID->EX pipeline register with an optional second (skid) entry for full throughput under back-pressure.
// Define ID_EX_SKID_EN for the two-entry skid mode; the default build holds a single entry.
module id_ex_skid_stage #(
    parameter int ALUOP_W  = 8,
    parameter int ALUSEL_W = 3,
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                id_valid,
    output logic                id_ready,
    input  logic [ALUOP_W-1:0]  id_aluop,
    input  logic [ALUSEL_W-1:0] id_alusel,
    input  logic [DATA_W-1:0]   id_reg1,
    input  logic [DATA_W-1:0]   id_reg2,
    input  logic [ADDR_W-1:0]   id_wd,
    input  logic                id_wreg,
    output logic                ex_valid,
    input  logic                ex_ready,
    output logic [ALUOP_W-1:0]  ex_aluop,
    output logic [ALUSEL_W-1:0] ex_alusel,
    output logic [DATA_W-1:0]   ex_reg1,
    output logic [DATA_W-1:0]   ex_reg2,
    output logic [ADDR_W-1:0]   ex_wd,
    output logic                ex_wreg,
    output logic [1:0]          occupancy
);
    localparam int BW = ALUOP_W + ALUSEL_W + 2 * DATA_W + ADDR_W + 1;

    // Handshake: a bundle moves on a rising edge only when valid and ready are both high;
    // valid never depends on ready, and a held bundle stays put until it is consumed.
    logic [BW-1:0] id_bundle;
    logic [BW-1:0] main_q, main_d;
    logic [1:0]    occ_q, occ_d;
    logic          in_xfer, out_xfer;

    assign id_bundle = {id_aluop, id_alusel, id_reg1, id_reg2, id_wd, id_wreg};
    assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg} = main_q;
    assign ex_valid  = (occ_q != 2'd0);
    assign occupancy = occ_q;
    assign in_xfer   = id_valid & id_ready;
    assign out_xfer  = ex_valid & ex_ready;

`ifdef ID_EX_SKID_EN
    logic [BW-1:0] skid_q, skid_d;
    logic          rdy_q, rdy_d;

    assign id_ready = rdy_q;
`else
    assign id_ready = ~ex_valid | ex_ready;
`endif

    // main_q is zeroed whenever the stage empties so the outputs read as a NOP.
    always_comb begin
        main_d = main_q;
        occ_d  = occ_q;
`ifdef ID_EX_SKID_EN
        skid_d = skid_q;
`endif
        case (occ_q)
            2'd0: begin
                if (in_xfer) begin
                    main_d = id_bundle;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (in_xfer && out_xfer) begin
                    main_d = id_bundle;
`ifdef ID_EX_SKID_EN
                end else if (in_xfer) begin
                    skid_d = id_bundle;
                    occ_d  = 2'd2;
`endif
                end else if (out_xfer) begin
                    main_d = '0;
                    occ_d  = 2'd0;
                end
            end
`ifdef ID_EX_SKID_EN
            2'd2: begin
                if (out_xfer) begin
                    main_d = skid_q;
                    skid_d = '0;
                    occ_d  = 2'd1;
                end
            end
`endif
            default: begin
                main_d = '0;
                occ_d  = 2'd0;
            end
        endcase
        if (flush) begin
            main_d = '0;
            occ_d  = 2'd0;
`ifdef ID_EX_SKID_EN
            skid_d = '0;
`endif
        end
`ifdef ID_EX_SKID_EN
        rdy_d = (occ_d != 2'd2);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            occ_q  <= 2'd0;
`ifdef ID_EX_SKID_EN
            skid_q <= '0;
            rdy_q  <= 1'b1;
`endif
        end else begin
            main_q <= main_d;
            occ_q  <= occ_d;
`ifdef ID_EX_SKID_EN
            skid_q <= skid_d;
            rdy_q  <= rdy_d;
`endif
        end
    end
endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Directed bench for id_ex_skid_stage: vector table, stall/flush/reset sequences, 100-bundle ordering run.
module tb_id_ex_skid_stage;
  typedef struct packed {
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
  } bnd_t;

  typedef struct {
    logic rst, flush, vld, rdy;
    bnd_t in_b;
    logic e_valid;
    logic [1:0] e_occ;
    logic e_irdy;
    bnd_t e_b;
  } vec_t;

  logic clk, rst, flush, id_valid, ex_ready;
  bnd_t id_b, ex_b;
  logic id_ready, ex_valid;
  logic [7:0] ex_aluop;
  logic [2:0] ex_alusel;
  logic [31:0] ex_reg1, ex_reg2;
  logic [4:0] ex_wd;
  logic ex_wreg;
  logic [1:0] occupancy;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  assign ex_b = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg};

  id_ex_skid_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .id_valid(id_valid), .id_ready(id_ready),
    .id_aluop(id_b.aluop), .id_alusel(id_b.alusel), .id_reg1(id_b.reg1),
    .id_reg2(id_b.reg2), .id_wd(id_b.wd), .id_wreg(id_b.wreg),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_aluop(ex_aluop), .ex_alusel(ex_alusel), .ex_reg1(ex_reg1),
    .ex_reg2(ex_reg2), .ex_wd(ex_wd), .ex_wreg(ex_wreg),
    .occupancy(occupancy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic f, input logic v, input logic er, input bnd_t b);
    rst = r; flush = f; id_valid = v; ex_ready = er; id_b = b;
  endtask

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_state(input string name, input logic ev, input logic [1:0] occ,
                              input logic irdy, input bnd_t b);
    check({name, ".ex_valid"}, 96'(ex_valid), 96'(ev));
    check({name, ".occupancy"}, 96'(occupancy), 96'(occ));
    check({name, ".id_ready"}, 96'(id_ready), 96'(irdy));
    check({name, ".bundle"}, 96'(ex_b), 96'(b));
  endtask

  function automatic bnd_t mk(input int t);
    bnd_t b;
    logic [15:0] tg;
    tg = t[15:0];
    b.aluop  = tg[7:0] ^ 8'h5A;
    b.alusel = tg[2:0];
    b.reg1   = {16'hC0DE, tg};
    b.reg2   = ~{16'hC0DE, tg};
    b.wd     = tg[4:0];
    b.wreg   = tg[0];
    return b;
  endfunction

  localparam bnd_t BA = '{8'h11, 3'd1, 32'hDEADBEEF, 32'h12345678, 5'd7, 1'b1};
  localparam bnd_t BB = '{8'h22, 3'd2, 32'h00000001, 32'h00000002, 5'd3, 1'b0};
  localparam bnd_t BC = '{8'h33, 3'd3, 32'hAAAA5555, 32'h0F0F0F0F, 5'd31, 1'b1};
  localparam bnd_t BD = '{8'h44, 3'd4, 32'h44444444, 32'h55555555, 5'd4, 1'b1};
  localparam bnd_t BE = '{8'h55, 3'd5, 32'hCAFEF00D, 32'h00000000, 5'd1, 1'b1};
  localparam bnd_t BF = '{8'hFF, 3'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd31, 1'b1};
  localparam bnd_t BR = '{8'h21, 3'd0, 32'h0, 32'h0, 5'd0, 1'b0};
  localparam bnd_t BZ = '0;

`ifdef ID_EX_SKID_EN
  localparam logic STALL_RDY = 1'b1;
  localparam logic [1:0] FULL_OCC = 2'd2;
`else
  localparam logic STALL_RDY = 1'b0;
  localparam logic [1:0] FULL_OCC = 2'd1;
`endif

  vec_t vecs[11];

  initial begin
    int sent, recv, cyc;
    logic [15:0] t;

    // reset hold, pass-through, flush, flush+reset; ex_ready=1 so both modes agree
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, BR, 1'b0, 2'd0, 1'b1, BZ};
    vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, BR, 1'b0, 2'd0, 1'b1, BZ};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, BA, 1'b1, 2'd1, 1'b1, BA};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, BB, 1'b1, 2'd1, 1'b1, BB};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, BZ, 1'b0, 2'd0, 1'b1, BZ};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, BC, 1'b1, 2'd1, 1'b1, BC};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, BD, 1'b0, 2'd0, 1'b1, BZ};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, BZ, 1'b0, 2'd0, 1'b1, BZ};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, BE, 1'b1, 2'd1, 1'b1, BE};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, BF, 1'b0, 2'd0, 1'b1, BZ};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, BZ, 1'b0, 2'd0, 1'b1, BZ};

    drive(1'b1, 1'b0, 1'b0, 1'b0, BZ);
    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].vld, vecs[i].rdy, vecs[i].in_b);
      tick();
      expect_state($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_occ, vecs[i].e_irdy, vecs[i].e_b);
    end

    // stall: A held, B goes to skid (or is refused), A stays stable, then flush discards all
    drive(1'b0, 1'b0, 1'b1, 1'b0, BA); tick();
    expect_state("stall_a", 1'b1, 2'd1, STALL_RDY, BA);
    drive(1'b0, 1'b0, 1'b1, 1'b0, BB); tick();
    expect_state("stall_b", 1'b1, FULL_OCC, 1'b0, BA);
    drive(1'b0, 1'b0, 1'b0, 1'b0, BZ); tick();
    expect_state("stall_hold", 1'b1, FULL_OCC, 1'b0, BA);
    drive(1'b0, 1'b1, 1'b1, 1'b1, BC); tick();
    expect_state("flush_full", 1'b0, 2'd0, 1'b1, BZ);
    drive(1'b0, 1'b0, 1'b0, 1'b1, BZ); tick();
    expect_state("post_flush1", 1'b0, 2'd0, 1'b1, BZ);
    tick();
    expect_state("post_flush2", 1'b0, 2'd0, 1'b1, BZ);

    // drain in order after back-pressure releases
    drive(1'b0, 1'b0, 1'b1, 1'b0, BA); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, BB); tick();
    expect_state("drain_full", 1'b1, FULL_OCC, 1'b0, BA);
`ifdef ID_EX_SKID_EN
    drive(1'b0, 1'b0, 1'b0, 1'b1, BZ); tick();
`else
    drive(1'b0, 1'b0, 1'b1, 1'b1, BB); tick();
`endif
    expect_state("drain_b", 1'b1, 2'd1, 1'b1, BB);
    drive(1'b0, 1'b0, 1'b0, 1'b1, BZ); tick();
    expect_state("drain_empty", 1'b0, 2'd0, 1'b1, BZ);

    // reset mid-operation with the stage full
    drive(1'b0, 1'b0, 1'b1, 1'b0, BD); tick();
    drive(1'b0, 1'b0, 1'b1, 1'b0, BE); tick();
    expect_state("rst_full", 1'b1, FULL_OCC, 1'b0, BD);
    drive(1'b1, 1'b0, 1'b1, 1'b1, BC); tick();
    expect_state("rst_mid", 1'b0, 2'd0, 1'b1, BZ);
    drive(1'b0, 1'b0, 1'b0, 1'b1, BZ); tick();
    expect_state("rst_after", 1'b0, 2'd0, 1'b1, BZ);

    // 100 back-to-back bundles with random back-pressure; scoreboard checks order
    sent = 0; recv = 0; cyc = 0;
    while (recv < 100 && cyc < 3000) begin
      drive(1'b0, 1'b0, (sent < 100), 1'($urandom_range(0, 1)), mk(sent));
      #3;
      if (id_valid && id_ready) begin
        exp_q.push_back(sent[15:0]);
        sent++;
      end
      if (ex_valid && ex_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL rand_extra: got %h expected nothing", ex_b);
        end else begin
          t = exp_q.pop_front();
          check($sformatf("rand_bundle%0d", t), 96'(ex_b), 96'(mk(int'(t))));
        end
        recv++;
      end else if (!ex_valid) begin
        check("rand_nop", 96'(ex_b), 96'(0));
      end
`ifdef ID_EX_SKID_EN
      if (!id_ready) check("rand_stall_full", 96'(occupancy), 96'(2));
`else
      check("rand_occ_max", 96'(occupancy > 2'd1), 96'(0));
`endif
      tick();
      cyc++;
    end
    check("rand_received", 96'(recv), 96'(100));
    check("rand_queue_empty", 96'(exp_q.size()), 96'(0));
    drive(1'b0, 1'b0, 1'b0, 1'b1, BZ); tick();
    expect_state("rand_end", 1'b0, 2'd0, 1'b1, BZ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
